phase_sequencer: RTL

- Parametrised multi-cycle instruction phase sequencer for the RockWave core; the next generation of the fixed 5-phase FETCH..WRITEBACK controller.
- Drives one-hot phase enables to the datapath.
- Adds phase skipping (e.g. MEMORYACCESS for ALU ops), pipeline flush, halt at instruction boundary, illegal-state recovery and a retired-instruction counter.

---
 rtl/rockwave_phase_pkg.sv | 12 +
 rtl/phase_next_sel.sv | 28 ++
 rtl/phase_sequencer.sv | 81 ++++++++
 3 files changed

// File: rtl/rockwave_phase_pkg.sv
// rockwave_phase_pkg: shared phase indices, limits and index-width helper for the phase sequencer
package rockwave_phase_pkg;
  localparam int PH_FETCH = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXECUTE = 2;
  localparam int PH_MEMACC = 3;
  localparam int PH_WRITEBACK = 4;
  localparam int PHASE_MAX = 8;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/phase_next_sel.sv
// phase_next_sel: picks the lowest non-skipped phase above the current one, or flags instruction exit
module phase_next_sel #(
  parameter int N = 5
) (
  input  logic [N-1:0] cur,
  input  logic [N-1:0] skip,
  input  logic         last,
  output logic [N-1:0] nxt,
  output logic         done
);
  logic [N-1:0] cand;
  logic         seen;
  logic         found;
  always_comb begin
    cand = '0;
    seen = 1'b0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (seen && !skip[j] && !found) begin
        cand[j] = 1'b1;
        found = 1'b1;
      end
      seen = seen | cur[j];
    end
    nxt = last ? '0 : cand;
    done = last | ~found;
  end
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot multi-cycle instruction phase sequencer with skip, flush, halt, error recovery and instret
module phase_sequencer
  import rockwave_phase_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W = 32,
  localparam int IDX_W = idx_w(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PHASES-1:0] stall,
  input  logic [NUM_PHASES-1:0] skip,
  input  logic                  flush,
  input  logic                  halt_req,
  output logic [NUM_PHASES-1:0] phase,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  halted,
  output logic                  retire,
  output logic [CNT_W-1:0]      instret,
  output logic                  err
);
  localparam logic [NUM_PHASES-1:0] FETCH = NUM_PHASES'(1);
  logic [NUM_PHASES-1:0] state_q, state_d, nxt;
  logic [CNT_W-1:0]      instret_q, instret_d;
  logic                  retire_q, retire_d, err_q, err_d;
  logic                  done, illegal, idle;
  logic [IDX_W-1:0]      idx;
  phase_next_sel #(.N(NUM_PHASES)) u_sel (
    .cur (state_q),
    .skip(skip),
    .last(state_q[NUM_PHASES-1]),
    .nxt (nxt),
    .done(done)
  );
  assign idle = (state_q == '0);
  assign illegal = |(state_q & (state_q - FETCH));
  always_comb begin
    state_d = state_q;
    instret_d = instret_q;
    retire_d = 1'b0;
    err_d = err_q;
    if (idle) state_d = halt_req ? '0 : FETCH;
    else if (illegal) begin
      state_d = FETCH;
      err_d = 1'b1;
    end
    else if (flush) state_d = FETCH;
    else if (state_q[0] && halt_req) state_d = '0;
    else if (|(state_q & stall)) state_d = state_q;
    else if (done) begin
      state_d = halt_req ? '0 : FETCH;
      retire_d = 1'b1;
      instret_d = instret_q + CNT_W'(1);
    end
    else state_d = nxt;
  end
  always_comb begin
    idx = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (state_q[i]) idx = IDX_W'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      instret_q <= '0;
      retire_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instret_q <= instret_d;
      retire_q <= retire_d;
      err_q <= err_d;
    end
  end
  assign phase = state_q;
  assign phase_idx = idx;
  assign halted = idle;
  assign retire = retire_q;
  assign instret = instret_q;
  assign err = err_q;
endmodule
